// File: rtl/source_split.sv
// source_split: demultiplexes a byte stream of header-prefixed TS packets onto four channels.
// Each packet is HDR_LEN pseudo-header bytes (PLP ID, PLP ID + 2, zeros) followed by TS_LEN
// TS bytes starting with SYNC_BYTE. Good packets are forwarded one cycle late on a shared
// registered data bus, qualified per channel; anything malformed is dropped and counted.
//
// Ports:
//   SYS_CLK     single clock, rising edge
//   RST         synchronous active-high reset
//   DATA_IN     input stream byte
//   D_VALID_IN  high for every byte of a packet, low for >= 1 cycle between packets
//   P_SYNC_IN   high on the first TS byte (stream index HDR_LEN)
//   DATA_OUT    registered TS byte, shared by all channels
//   VALID_OUT   one-hot channel qualifier for DATA_OUT
//   P_SYNC_OUT  one-hot marker of the sync byte
//   PKT_END     one-hot pulse with the last TS byte
//   PKT_ERR     one-hot pulse when a packet being forwarded is cut short
//   ERR_CNT     saturating count of rejected or damaged packets (ERR_W bits, default 16)
module source_split #(
    parameter int unsigned HDR_LEN   = 4,
    parameter int unsigned TS_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic [7:0]       DATA_IN,
    input  logic             D_VALID_IN,
    input  logic             P_SYNC_IN,
    output logic [7:0]       DATA_OUT,
    output logic [3:0]       VALID_OUT,
    output logic [3:0]       P_SYNC_OUT,
    output logic [3:0]       PKT_END,
    output logic [3:0]       PKT_ERR,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHeader  = 2'd1;
    localparam logic [1:0] StPayload = 2'd2;
    localparam logic [1:0] StDiscard = 2'd3;

    localparam logic [7:0] HdrLast  = 8'(HDR_LEN - 1);
    localparam logic [7:0] SyncIdx  = 8'(HDR_LEN);
    localparam logic [7:0] LastIdx  = 8'(HDR_LEN + TS_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       hdr0_q, hdr0_d;
    logic             hdr_ok_q, hdr_ok_d;
    logic [1:0]       ch_q, ch_d;
    // Cleared by reset; a packet may only start after D_VALID_IN has been seen low, so the
    // tail of a packet interrupted by reset is not mistaken for a new header.
    logic             armed_q, armed_d;
    // Set for one cycle after the last TS byte, to catch a missing inter-packet gap.
    logic             last_q, last_d;
    // An error was already counted for the current packet.
    logic             err_seen_q, err_seen_d;
    logic [ERR_W-1:0] err_cnt_q;

    logic [7:0] data_out_q;
    logic [3:0] valid_out_q, p_sync_out_q, pkt_end_q, pkt_err_q;

    logic       pkt_start, err_evt, err_inc;
    logic       fwd, fwd_sync, fwd_end, trunc;
    logic       hdr_ok_now;
    logic [3:0] ch_oh;

    assign ch_oh = 4'b0001 << ch_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr0_d     = hdr0_q;
        hdr_ok_d   = hdr_ok_q;
        ch_d       = ch_q;
        armed_d    = armed_q | ~D_VALID_IN;
        last_d     = 1'b0;
        pkt_start  = 1'b0;
        err_evt    = 1'b0;
        fwd        = 1'b0;
        fwd_sync   = 1'b0;
        fwd_end    = 1'b0;
        trunc      = 1'b0;
        hdr_ok_now = hdr_ok_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (D_VALID_IN && armed_q) begin
                    if (last_q) begin
                        // Previous packet ran on without a gap.
                        err_evt = 1'b1;
                        state_d = StDiscard;
                    end else begin
                        pkt_start = 1'b1;
                        err_evt   = P_SYNC_IN;
                        hdr0_d    = DATA_IN;
                        hdr_ok_d  = (DATA_IN < 8'd4);
                        cnt_d     = 8'd1;
                        state_d   = StHeader;
                    end
                end
            end

            StHeader: begin
                if (!D_VALID_IN) begin
                    err_evt = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    err_evt    = P_SYNC_IN;
                    hdr_ok_now = hdr_ok_q & ((cnt_q == 8'd1) ? (DATA_IN == hdr0_q + 8'd2)
                                                             : (DATA_IN == 8'h00));
                    hdr_ok_d   = hdr_ok_now;
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q == HdrLast) begin
                        if (hdr_ok_now) begin
                            ch_d    = hdr0_q[1:0];
                            state_d = StPayload;
                        end else begin
                            err_evt = 1'b1;
                            state_d = StDiscard;
                        end
                    end
                end
            end

            StPayload: begin
                if (!D_VALID_IN) begin
                    err_evt = 1'b1;
                    // Only flag truncation once bytes have actually gone out.
                    trunc   = (cnt_q != SyncIdx);
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end else if (cnt_q == SyncIdx) begin
                    if (!P_SYNC_IN || DATA_IN != SYNC_BYTE) begin
                        err_evt = 1'b1;
                        state_d = StDiscard;
                    end else begin
                        fwd      = 1'b1;
                        fwd_sync = 1'b1;
                        cnt_d    = cnt_q + 8'd1;
                    end
                end else begin
                    fwd     = 1'b1;
                    err_evt = P_SYNC_IN;
                    if (cnt_q == LastIdx) begin
                        fwd_end = 1'b1;
                        last_d  = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            StDiscard: begin
                if (!D_VALID_IN) begin
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end
            end

            default: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
        endcase

        err_inc    = err_evt && (pkt_start || !err_seen_q) && (err_cnt_q != '1);
        err_seen_d = (pkt_start ? 1'b0 : err_seen_q) | err_evt;
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            hdr0_q       <= 8'd0;
            hdr_ok_q     <= 1'b0;
            ch_q         <= 2'd0;
            armed_q      <= 1'b0;
            last_q       <= 1'b0;
            err_seen_q   <= 1'b0;
            err_cnt_q    <= '0;
            data_out_q   <= 8'd0;
            valid_out_q  <= 4'd0;
            p_sync_out_q <= 4'd0;
            pkt_end_q    <= 4'd0;
            pkt_err_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hdr0_q       <= hdr0_d;
            hdr_ok_q     <= hdr_ok_d;
            ch_q         <= ch_d;
            armed_q      <= armed_d;
            last_q       <= last_d;
            err_seen_q   <= err_seen_d;
            if (err_inc) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            if (fwd) begin
                data_out_q <= DATA_IN;
            end
            valid_out_q  <= fwd      ? ch_oh : 4'd0;
            p_sync_out_q <= fwd_sync ? ch_oh : 4'd0;
            pkt_end_q    <= fwd_end  ? ch_oh : 4'd0;
            pkt_err_q    <= trunc    ? ch_oh : 4'd0;
        end
    end

    assign DATA_OUT   = data_out_q;
    assign VALID_OUT  = valid_out_q;
    assign P_SYNC_OUT = p_sync_out_q;
    assign PKT_END    = pkt_end_q;
    assign PKT_ERR    = pkt_err_q;
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: doc/source_split.md
SOURCE_SPLIT -- requirements
Module: source_split

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): HDR_LEN, 4, pseudo-header bytes per packet.
REQ-002 The block SHALL have parameter TS_LEN, 188, TS packet bytes following the header.
REQ-003 The block SHALL have parameter SYNC_BYTE, 8'h47, required value of the first TS byte.
REQ-004 The block SHALL have port SYS_CLK  in  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port DATA_IN  in  8  muxed stream byte.
REQ-007 The block SHALL have port D_VALID_IN  in  1  high for the HDR_LEN+TS_LEN bytes of one packet, low for at least 1 cycle between packets.
REQ-008 The block SHALL have port P_SYNC_IN  in  1  high on the first TS byte only (stream byte index 4).
REQ-009 The block SHALL have port DATA_OUT  out  8  registered TS byte, shared by all channels.
REQ-010 The block SHALL have port VALID_OUT  out  4  one-hot; bit n qualifies DATA_OUT for channel n.
REQ-011 The block SHALL have port P_SYNC_OUT  out  4  one-hot; marks the 0x47 byte of channel n.
REQ-012 The block SHALL have port PKT_END  out  4  1-cycle pulse with the last (188th) TS byte of channel n.
REQ-013 The block SHALL have port PKT_ERR  out  4  1-cycle pulse when a packet already being forwarded to channel n is truncated.
REQ-014 The block SHALL have port ERR_CNT  out  16  saturating count of all rejected or damaged packets.

Function
REQ-015 Stream format SHALL be: byte0 PLP ID (0..3), byte1 = PLP ID + 2, byte2 = 0x00, byte3 = 0x00, bytes 4..191 = TS packet.
REQ-016 The FSM SHALL have states IDLE, HEADER, PAYLOAD and DISCARD, with an 8-bit byte counter cleared on every entry to IDLE.
REQ-017 IDLE: when D_VALID_IN=1, the block SHALL capture byte0, set counter to 1, and go to HEADER; otherwise it SHALL stay in IDLE.
REQ-018 HEADER: the block SHALL capture bytes 1..3; after byte3, if byte0<4, byte1==byte0+2 and byte2==byte3==0, it SHALL go to PAYLOAD with channel = byte0[1:0]; otherwise it SHALL count an error and go to DISCARD.
REQ-019 PAYLOAD first byte (index 4): if P_SYNC_IN=0 or DATA_IN!=SYNC_BYTE, the block SHALL forward nothing, count an error, and go to DISCARD.
REQ-020 PAYLOAD: each valid byte SHALL appear on DATA_OUT with VALID_OUT[ch]=1 exactly 1 cycle later; P_SYNC_OUT[ch] SHALL be high with byte index 4 only.
REQ-021 PKT_END[ch] SHALL pulse together with the byte of index 191; the FSM SHALL then go to IDLE if D_VALID_IN falls on the next cycle, otherwise it SHALL count an error and go to DISCARD.
REQ-022 D_VALID_IN=0 in HEADER SHALL count an error and go to IDLE with no output activity.
REQ-023 D_VALID_IN=0 in PAYLOAD before index 191 SHALL pulse PKT_ERR[ch] on the next cycle, count an error, and go to IDLE; PKT_END SHALL NOT pulse.
REQ-024 P_SYNC_IN=1 at any index other than 4 SHALL be ignored for routing but counted as one error per packet.
REQ-025 DISCARD: the block SHALL hold all VALID_OUT/P_SYNC_OUT at 0 and go to IDLE on the first cycle with D_VALID_IN=0.
REQ-026 ERR_CNT SHALL increment by at most 1 per packet and SHALL saturate at 16'hFFFF without wrapping.
REQ-027 At most one bit of VALID_OUT, P_SYNC_OUT, PKT_END and PKT_ERR combined SHALL be high in any cycle.
REQ-028 The minimum inter-packet gap SHALL be 1 cycle; back-to-back packets to any channel sequence SHALL be accepted without loss.

Reset
REQ-029 With RST=1 on a clock edge, the block SHALL set state IDLE, counter 0, DATA_OUT 0, VALID_OUT/P_SYNC_OUT/PKT_END/PKT_ERR 0, and ERR_CNT 0.
REQ-030 A reset mid-packet SHALL abort that packet without a PKT_ERR pulse; the remainder of the packet SHALL be treated as a fresh IDLE start only once D_VALID_IN has gone low.

Verification
REQ-031 The bench SHALL cover: packet with hdr 02 04 00 00 + 47 + 187 bytes -> VALID_OUT=4'b0100 for 188 cycles, P_SYNC_OUT[2] on 0x47, PKT_END[2] on the last byte, ERR_CNT=0.
REQ-032 The bench SHALL cover: four packets on channels 0,1,2,3 with 1-cycle gaps -> four 188-byte bursts routed in order, no errors.
REQ-033 The bench SHALL cover: hdr 01 05 00 00 -> no output, ERR_CNT=1, and the next good packet is routed normally.
REQ-034 The bench SHALL cover: good hdr with first TS byte 0x46 -> no output, ERR_CNT+1.
REQ-035 The bench SHALL cover: D_VALID_IN dropped after 100 TS bytes on channel 3 -> 100 bytes output, PKT_ERR[3] pulse, no PKT_END, ERR_CNT+1.
REQ-036 The bench SHALL cover: ERR_CNT preloaded to 0xFFFF via 65535 bad packets, plus one more bad packet -> ERR_CNT stays at 0xFFFF; RST=1 mid-payload -> all outputs 0 next cycle.
